// File: rtl/floor_req_bank_pkg.sv
// elevator_pkg: shared floor-bank constants and types.
//   FLOORS_DEF  default number of floors / request bits
//   FLOOR_W_DEF floor index width derived from FLOORS_DEF
//   floor_t     floor index type for the default configuration
//   NO_FLOOR    index reported by near_* / starve_floor when nothing qualifies
package elevator_pkg;

    localparam int unsigned FLOORS_DEF  = 8;
    localparam int unsigned FLOOR_W_DEF = $clog2(FLOORS_DEF);

    typedef logic [FLOOR_W_DEF-1:0] floor_t;

    localparam int unsigned NO_FLOOR = 0;

endpackage

// File: rtl/floor_req_bank_cell.sv
// req_bit_cell: one sticky request latch.
//   clk       rising-edge clock
//   clr_n     synchronous active-low reset
//   en        update enable; 0 holds the bit (and its age)
//   set       request pulse (wins over clr)
//   clr       served pulse
//   q         latched request
//   q_next    value q takes on the next edge (feeds the bank's registered summaries)
//   age_next  next value of the age counter (only with FLOOR_REQ_STARVE_DET_EN)
// Optional feature macro: FLOOR_REQ_STARVE_DET_EN builds the per-bit age counter.
module req_bit_cell
`ifdef FLOOR_REQ_STARVE_DET_EN
#(
    parameter int unsigned AGE_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             set,
    input  logic             clr,
    output logic             q,
    output logic             q_next
`ifdef FLOOR_REQ_STARVE_DET_EN
    ,
    output logic [AGE_W-1:0] age_next
`endif
);

    always_comb begin
        q_next = en ? (set | (q & ~clr)) : q;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else begin
            q <= q_next;
        end
    end

`ifdef FLOOR_REQ_STARVE_DET_EN
    logic [AGE_W-1:0] age;

    // Age restarts only when the bit drops; a re-press on a pending bit keeps
    // counting so repeated presses cannot hide a starved floor.
    always_comb begin
        age_next = age;
        if (!q_next) begin
            age_next = '0;
        end else if (en && q && (age != '1)) begin
            age_next = age + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            age <= '0;
        end else begin
            age <= age_next;
        end
    end
`endif

endmodule

// File: rtl/floor_req_bank.sv
// floor_req_bank: bank of sticky per-floor request latches with registered
// summary outputs for the elevator controller.
//   clk, clr_n          clock, synchronous active-low reset
//   en                  update enable (summaries still reload every edge)
//   set_vec / clr_vec   request / served pulses, bit i = floor i
//   cur_floor           current car floor
//   pending             latched requests
//   pending_cnt         popcount of pending (0..FLOORS)
//   any_above/any_below pending request above / below cur_floor
//   at_floor            request pending at cur_floor
//   near_above          lowest pending index above cur_floor, else NO_FLOOR
//   near_below          highest pending index below cur_floor, else NO_FLOOR
//   starve/starve_floor request aged >= AGE_LIMIT, lowest such index
// Optional feature macro: FLOOR_REQ_STARVE_DET_EN enables the age counters;
// without it starve and starve_floor are constant 0.
module floor_req_bank
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS    = FLOORS_DEF,
    parameter int unsigned FLOOR_W   = $clog2(FLOORS),
    parameter int unsigned AGE_W     = 8,
    parameter int unsigned AGE_LIMIT = 200
)(
    input  logic               clk,
    input  logic               clr_n,
    input  logic               en,
    input  logic [FLOORS-1:0]  set_vec,
    input  logic [FLOORS-1:0]  clr_vec,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOOR_W:0]   pending_cnt,
    output logic               any_above,
    output logic               any_below,
    output logic               at_floor,
    output logic [FLOOR_W-1:0] near_above,
    output logic [FLOOR_W-1:0] near_below,
    output logic               starve,
    output logic [FLOOR_W-1:0] starve_floor
);

    typedef logic [FLOOR_W:0] cnt_t;

    logic [FLOORS-1:0]  pend_nx;
    logic [31:0]        cur_u;
    logic               cur_in;
    cnt_t               cnt_nx;
    logic               above_nx;
    logic               below_nx;
    logic               at_nx;
    logic [FLOOR_W-1:0] na_nx;
    logic [FLOOR_W-1:0] nb_nx;
    logic               starve_nx;
    logic [FLOOR_W-1:0] sfloor_nx;

`ifdef FLOOR_REQ_STARVE_DET_EN
    localparam logic [AGE_W-1:0] AGE_LIM_V = AGE_W'(AGE_LIMIT);
    logic [AGE_W-1:0] age_nx [FLOORS];
`endif

    for (genvar g = 0; g < FLOORS; g++) begin : g_cell
        req_bit_cell
`ifdef FLOOR_REQ_STARVE_DET_EN
        #(
            .AGE_W (AGE_W)
        )
`endif
        u_cell (
            .clk      (clk),
            .clr_n    (clr_n),
            .en       (en),
            .set      (set_vec[g]),
            .clr      (clr_vec[g]),
            .q        (pending[g]),
            .q_next   (pend_nx[g])
`ifdef FLOOR_REQ_STARVE_DET_EN
            ,
            .age_next (age_nx[g])
`endif
        );
    end

    assign cur_u  = 32'(cur_floor);
    assign cur_in = (cur_u < FLOORS);

    // Summaries are computed from next-state pending so they land on the same
    // edge as pending itself. An out-of-range cur_floor treats every pending
    // bit as "below".
    always_comb begin
        cnt_nx   = '0;
        above_nx = 1'b0;
        below_nx = 1'b0;
        at_nx    = 1'b0;
        na_nx    = FLOOR_W'(NO_FLOOR);
        nb_nx    = FLOOR_W'(NO_FLOOR);
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (pend_nx[i]) begin
                cnt_nx = cnt_nx + cnt_t'(1);
                if (!cur_in) begin
                    below_nx = 1'b1;
                    nb_nx    = FLOOR_W'(i);
                end else if (i == cur_u) begin
                    at_nx = 1'b1;
                end else if (i > cur_u) begin
                    if (!above_nx) begin
                        above_nx = 1'b1;
                        na_nx    = FLOOR_W'(i);
                    end
                end else begin
                    below_nx = 1'b1;
                    nb_nx    = FLOOR_W'(i);
                end
            end
        end
    end

`ifdef FLOOR_REQ_STARVE_DET_EN
    always_comb begin
        starve_nx = 1'b0;
        sfloor_nx = FLOOR_W'(NO_FLOOR);
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (!starve_nx && (age_nx[i] >= AGE_LIM_V)) begin
                starve_nx = 1'b1;
                sfloor_nx = FLOOR_W'(i);
            end
        end
    end
`else
    assign starve_nx = 1'b0;
    assign sfloor_nx = '0;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pending_cnt  <= '0;
            any_above    <= 1'b0;
            any_below    <= 1'b0;
            at_floor     <= 1'b0;
            near_above   <= '0;
            near_below   <= '0;
            starve       <= 1'b0;
            starve_floor <= '0;
        end else begin
            pending_cnt  <= cnt_nx;
            any_above    <= above_nx;
            any_below    <= below_nx;
            at_floor     <= at_nx;
            near_above   <= na_nx;
            near_below   <= nb_nx;
            starve       <= starve_nx;
            starve_floor <= sfloor_nx;
        end
    end

endmodule

// File: tb/tb_floor_req_bank.sv
// Directed testbench for floor_req_bank: table of single-cycle vectors plus
// hand sequences for reset, starvation timing and an out-of-range floor.
module tb_floor_req_bank;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       en;
    logic [7:0] set_vec, clr_vec;
    logic [2:0] cur_floor;
    logic [7:0] pending;
    logic [3:0] pending_cnt;
    logic       any_above, any_below, at_floor, starve;
    logic [2:0] near_above, near_below, starve_floor;

    // Six-floor instance: a 3-bit cur_floor of 6 or 7 is out of range.
    logic       en6;
    logic [5:0] set6, clr6;
    logic [2:0] cur6;
    logic [5:0] pend6;
    logic [3:0] cnt6;
    logic       above6, below6, at6, starve6;
    logic [2:0] na6, nb6, sf6;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_starve_en;

    always #5 clk = ~clk;

    floor_req_bank #(
        .FLOORS    (8),
        .AGE_W     (8),
        .AGE_LIMIT (5)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .en           (en),
        .set_vec      (set_vec),
        .clr_vec      (clr_vec),
        .cur_floor    (cur_floor),
        .pending      (pending),
        .pending_cnt  (pending_cnt),
        .any_above    (any_above),
        .any_below    (any_below),
        .at_floor     (at_floor),
        .near_above   (near_above),
        .near_below   (near_below),
        .starve       (starve),
        .starve_floor (starve_floor)
    );

    floor_req_bank #(
        .FLOORS    (6),
        .AGE_W     (8),
        .AGE_LIMIT (200)
    ) dut6 (
        .clk          (clk),
        .clr_n        (clr_n),
        .en           (en6),
        .set_vec      (set6),
        .clr_vec      (clr6),
        .cur_floor    (cur6),
        .pending      (pend6),
        .pending_cnt  (cnt6),
        .any_above    (above6),
        .any_below    (below6),
        .at_floor     (at6),
        .near_above   (na6),
        .near_below   (nb6),
        .starve       (starve6),
        .starve_floor (sf6)
    );

    typedef struct {
        logic [7:0] set;
        logic [7:0] clr;
        logic       en;
        logic [2:0] cur;
        logic [7:0] pend;
        logic [3:0] cnt;
        logic       above;
        logic       below;
        logic       at;
        logic [2:0] na;
        logic [2:0] nb;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".pending"},    32'(pending),     32'(v.pend));
        chk({tag, ".cnt"},        32'(pending_cnt), 32'(v.cnt));
        chk({tag, ".any_above"},  32'(any_above),   32'(v.above));
        chk({tag, ".any_below"},  32'(any_below),   32'(v.below));
        chk({tag, ".at_floor"},   32'(at_floor),    32'(v.at));
        chk({tag, ".near_above"}, 32'(near_above),  32'(v.na));
        chk({tag, ".near_below"}, 32'(near_below),  32'(v.nb));
    endtask

    initial begin
`ifdef FLOOR_REQ_STARVE_DET_EN
        exp_starve_en = 1'b1;
`else
        exp_starve_en = 1'b0;
`endif
        //            set    clr    en    cur   pend   cnt  abv bel at  na  nb
        vecs[0] = '{8'h92, 8'h00, 1'b1, 3'd3, 8'h92, 4'd3, 1, 1, 0, 3'd4, 3'd1};
        vecs[1] = '{8'h10, 8'h10, 1'b1, 3'd3, 8'h92, 4'd3, 1, 1, 0, 3'd4, 3'd1};
        vecs[2] = '{8'h01, 8'hFF, 1'b0, 3'd3, 8'h92, 4'd3, 1, 1, 0, 3'd4, 3'd1};
        vecs[3] = '{8'h01, 8'hFF, 1'b0, 3'd7, 8'h92, 4'd3, 0, 1, 1, 3'd0, 3'd4};
        vecs[4] = '{8'h00, 8'h80, 1'b1, 3'd7, 8'h12, 4'd2, 0, 1, 0, 3'd0, 3'd4};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 3'd0, 8'hFF, 4'd8, 1, 0, 1, 3'd1, 3'd0};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 3'd0, 8'h00, 4'd0, 0, 0, 0, 3'd0, 3'd0};
        vecs[7] = '{8'h81, 8'h00, 1'b1, 3'd7, 8'h81, 4'd2, 0, 1, 1, 3'd0, 3'd0};
        vecs[8] = '{8'h28, 8'h81, 1'b1, 3'd4, 8'h28, 4'd2, 1, 1, 0, 3'd5, 3'd3};
        vecs[9] = '{8'h00, 8'hFF, 1'b1, 3'd0, 8'h00, 4'd0, 0, 0, 0, 3'd0, 3'd0};

        // Reset held with every set bit asserted.
        clr_n = 1'b0; en = 1'b1; set_vec = 8'hFF; clr_vec = 8'h00; cur_floor = 3'd3;
        en6 = 1'b1; set6 = 6'h3F; clr6 = 6'h00; cur6 = 3'd7;
        @(negedge clk);
        step();
        chk_all("reset", '{8'hFF, 8'h00, 1'b1, 3'd3, 8'h00, 4'd0, 0, 0, 0, 3'd0, 3'd0});
        chk("reset.starve", 32'(starve), 32'd0);
        chk("reset.starve_floor", 32'(starve_floor), 32'd0);
        chk("reset.dut6_pending", 32'(pend6), 32'd0);
        set_vec = 8'h00; set6 = 6'h00;
        clr_n = 1'b1;
        step();
        chk("idle.pending", 32'(pending), 32'd0);

        for (int i = 0; i < 10; i++) begin
            set_vec = vecs[i].set; clr_vec = vecs[i].clr;
            en = vecs[i].en; cur_floor = vecs[i].cur;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end
        set_vec = 8'h00; clr_vec = 8'h00; en = 1'b1;

        // Reset in the middle of activity overrides set/en.
        set_vec = 8'h0F; cur_floor = 3'd2;
        step();
        chk("midrst.pre_pending", 32'(pending), 32'h0F);
        clr_n = 1'b0; set_vec = 8'hFF;
        step();
        chk("midrst.pending", 32'(pending), 32'd0);
        chk("midrst.cnt", 32'(pending_cnt), 32'd0);
        chk("midrst.any_below", 32'(any_below), 32'd0);
        clr_n = 1'b1; set_vec = 8'h00;
        step();

        // Starvation: floor 2 pending with en held; age reaches 5 on the
        // 6th edge counted from the set edge.
        cur_floor = 3'd0; en = 1'b1;
        set_vec = 8'h04;
        for (int k = 1; k <= 6; k++) begin
            step();
            set_vec = 8'h00;
            chk($sformatf("starve.k%0d", k), 32'(starve), 32'(exp_starve_en && (k >= 6)));
            chk($sformatf("starve_floor.k%0d", k), 32'(starve_floor),
                (exp_starve_en && (k >= 6)) ? 32'd2 : 32'd0);
        end
        clr_vec = 8'h04;
        step();
        clr_vec = 8'h00;
        chk("starve.cleared", 32'(starve), 32'd0);
        chk("starve.cleared_pending", 32'(pending), 32'd0);

        // Out-of-range floor on the six-floor bank.
        set6 = 6'b100001; cur6 = 3'd7;
        step();
        set6 = 6'h00;
        chk("illegal.pending", 32'(pend6), 32'h21);
        chk("illegal.cnt", 32'(cnt6), 32'd2);
        chk("illegal.at_floor", 32'(at6), 32'd0);
        chk("illegal.any_above", 32'(above6), 32'd0);
        chk("illegal.near_above", 32'(na6), 32'd0);
        chk("illegal.any_below", 32'(below6), 32'd1);
        chk("illegal.near_below", 32'(nb6), 32'd5);
        cur6 = 3'd2;
        step();
        chk("dut6_legal.near_above", 32'(na6), 32'd5);
        chk("dut6_legal.near_below", 32'(nb6), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
